// File: rtl/wb_arbiter_if.sv
// Bundle of the write-back arbiter's bus signals: port A (MEM stage), port B (long-latency
// units), the registered register-file write stream and the pending-register mask.
interface wb_arbiter_if;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        w_req;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [31:0] pend_mask;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, w_req, w_addr, w_data, pend_mask
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, w_req, w_addr, w_data, pend_mask
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: in-order port A results take the register-file write port unless the
// buffered port-B head has starved or A would overtake an older B write to the same register.
module wb_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          rst,
  wb_arbiter_if.slave  bus
);

  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WaitW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [4:0]            addr_q [FIFO_DEPTH];
  logic [31:0]           data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] vld_q, vld_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [WaitW-1:0]      wait_q, wait_d;
  logic                  w_req_q, w_req_d;
  logic [4:0]            w_addr_q, w_addr_d;
  logic [31:0]           w_data_q, w_data_d;

  logic non_empty, force_b, waw, a_fire, push, pop;
  logic [31:0] pend;

  assign non_empty = (count_q != '0);
  assign force_b   = non_empty && (wait_q == WaitW'(STARVE_LIMIT));

  // Only valid entries take part; none of them ever targets r0.
  always_comb begin
    waw  = 1'b0;
    pend = '0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (vld_q[i]) begin
        pend[addr_q[i]] = 1'b1;
        if (addr_q[i] == bus.a_addr) waw = 1'b1;
      end
    end
    pend[0] = 1'b0;
  end

  assign bus.a_ready   = !force_b && !waw;
  assign bus.b_ready   = (count_q < CntW'(FIFO_DEPTH));
  assign bus.pend_mask = pend;
  assign bus.w_req     = w_req_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.w_data    = w_data_q;

  assign a_fire = bus.a_valid && bus.a_ready;
  assign push   = bus.b_valid && bus.b_ready && (bus.b_addr != '0);
  assign pop    = !a_fire && non_empty;

  always_comb begin
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PtrW'(1);
    end
    if (push) begin
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (pop || !non_empty) begin
      wait_d = '0;
    end else if (wait_q != WaitW'(STARVE_LIMIT)) begin
      wait_d = wait_q + WaitW'(1);
    end
  end

  always_comb begin
    w_req_d  = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    if (a_fire) begin
      w_req_d  = (bus.a_addr != '0);
      w_addr_d = bus.a_addr;
      w_data_d = bus.a_data;
    end else if (pop) begin
      w_req_d  = 1'b1;
      w_addr_d = addr_q[rd_ptr_q];
      w_data_d = data_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= '0;
      w_req_q  <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
      w_req_q  <= w_req_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  // Payload storage needs no reset; vld_q alone marks live entries.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= bus.b_addr;
      data_q[wr_ptr_q] <= bus.b_data;
    end
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter between the execute pipeline and the register file's single write port. Merges in-order results from the MEM stage (port A) with out-of-order completions from long-latency units (port B, e.g. multiplier/divider) into one registered write stream (w_req/w_addr/w_data) driving the register file. Port B results are buffered in a small FIFO with an aging counter against starvation. A pending-register mask is exported for hazard detection in ID.

## Interface
Parameters:
- FIFO_DEPTH, 2: port-B buffer entries (power of two, ≥2).
- STARVE_LIMIT, 4: cycles a non-empty FIFO head may wait before port A is blocked.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset (`RstEnable`).
- a_valid  in  1  MEM-stage result present.
- a_ready  out  1  port A accepted this cycle.
- a_addr  in  `RegAddrBus` (5)  destination register.
- a_data  in  `RegBus` (32)  result.
- b_valid  in  1  long-latency unit result present.
- b_ready  out  1  FIFO can take an entry.
- b_addr  in  5  destination register.
- b_data  in  32  result.
- w_req  out  1  register-file write enable (registered).
- w_addr  out  5  register-file write address (registered).
- w_data  out  32  register-file write data (registered).
- pend_mask  out  32  bit i set ⇔ FIFO holds an entry targeting register i.

## Operation
- Reset: FIFO empty, wait_cnt=0, w_req=0, w_addr=0, w_data=`ZeroWord`, pend_mask=0; a_ready and b_ready evaluate per rules below (b_ready=1, a_ready=1 after reset cycle).
- b_ready = (count < FIFO_DEPTH); depends only on registered count, no same-cycle pass-through.
- B handshake (b_valid&&b_ready): entry pushed at tail. b_addr==0: handshake completes, nothing pushed.
- a_ready = !force && !waw, where force = (count≠0 && wait_cnt==STARVE_LIMIT), waw = a_addr matches any valid FIFO entry address.
- Selection each cycle:
  - A handshake (a_valid&&a_ready) wins: next w_req=(a_addr≠0), w_addr=a_addr, w_data=a_data. FIFO head not popped.
  - Else if FIFO non-empty: pop head; next w_req=1, w_addr/w_data=head.
  - Else next w_req=0; w_addr/w_data hold.
- wait_cnt: reset to 0 on pop or when FIFO empty; else increments while head not popped, saturates at STARVE_LIMIT.
- Simultaneous push and pop: count unchanged, both pointers advance; pointers wrap modulo FIFO_DEPTH.
- Push when full impossible (b_ready=0); pop when empty impossible.
- pend_mask combinational from valid FIFO entries; bit 0 always 0. Entry's bit clears in the cycle after its pop.
- Port-B results never dropped or reordered among themselves (FIFO order).
- waw stall preserves program order: an older B result to rX is always written before a younger A result to rX.

## Timing
- Port A: handshake in cycle t → w_req/w_addr/w_data valid in t+1 (1-cycle latency). Register-file forwarding makes the value readable in t+1.
- Port B: push in t → earliest write output t+2 (head visible t+1, registered output t+2).
- Starvation bound: FIFO head written no later than STARVE_LIMIT+2 cycles after it became head.
- Throughput: one register-file write per cycle maximum.
- Reset asserted mid-operation: buffered B entries discarded, w_req=0 in the cycle after reset sampled; no write issued during reset cycles.

## Test plan
- Reset: assert rst 2 cycles with b_valid=1 → w_req=0, pend_mask=0, FIFO stays empty; after deassert b_ready=1.
- A only: a_valid=1, a_addr=5, a_data=0x1234 at t → w_req=1, w_addr=5, w_data=0x1234 at t+1; a_addr=0 → w_req=0.
- B only: b_addr=7, b_data=0xDEADBEEF at t → pend_mask=0x80 at t+1, write appears t+2, pend_mask=0 at t+2.
- Full/backpressure: a_valid=1 continuously (addrs 1..3), push B to regs 8,9 → b_ready=0 after two pushes; third B held; after wait_cnt reaches 4, a_ready=0 one cycle and reg 8 written; then reg 9 likewise.
- WAW: FIFO holds reg 10 = 0xAAAA; A presents reg 10 = 0xBBBB → a_ready=0, reg 10←0xAAAA first, then a_ready=1 and reg 10←0xBBBB next cycle.
- Simultaneous push/pop at count=1 with pointer wrap: sequence of 6 B results to regs 11-16, no A traffic → written in order 11..16, one per cycle after fill, no loss.
